// File: rtl/dm_rom_pkg.sv
// Shared types and defaults for the debug ROM request port.
package dm_rom_pkg;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rom_resp_t;

    localparam logic [63:0] DbgRomBase  = 64'h800;
    localparam int unsigned DbgRomWords = 19;

endpackage

// File: rtl/dm_rom_port_if.sv
// Valid/ready request and response channel between the debug-memory slave port and the ROM adapter.
interface dm_rom_port_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [63:0] req_addr_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

endinterface

// File: rtl/dm_rom_resp_fifo.sv
// Circular-buffer response FIFO; head reads as zero while empty.
module dm_rom_resp_fifo
    import dm_rom_pkg::*;
#(
    parameter  int unsigned Depth = 3,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_push,
    input  rom_resp_t       i_data,
    input  logic            i_pop,
    output rom_resp_t       o_head,
    output logic [CntW-1:0] o_count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    rom_resp_t       r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CntW'(Depth));
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(i_push && w_full)
    );

endmodule

// File: rtl/dm_rom_port.sv
// Debug ROM request adapter: window decode, one-cycle ROM strobe, in-order responses with backpressure.
module dm_rom_port
    import dm_rom_pkg::*;
#(
    parameter logic [63:0] BaseAddr  = DbgRomBase,
    parameter int unsigned RomSize   = DbgRomWords,
    parameter int unsigned FifoDepth = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    dm_rom_port_if.slave bus,
    output logic         rom_req_o,
    output logic [63:0]  rom_addr_o,
    input  logic [63:0]  rom_rdata_i
);

    localparam int unsigned CntW     = $clog2(FifoDepth + 1);
    localparam logic [63:0] RomBytes = 64'(RomSize) * 64'd8;
    localparam logic [CntW:0] DepthW = (CntW + 1)'(FifoDepth);

    logic [63:0]     w_offset;
    logic            w_hit;
    logic            w_ready;
    logic            w_accept;
    logic [CntW-1:0] w_count;
    logic [CntW:0]   w_occupancy;
    rom_resp_t       w_push_data;
    rom_resp_t       w_head;
    logic            w_pop;
    logic            r_s1_valid;
    logic            r_s1_err;

    assign w_offset = bus.req_addr_i - BaseAddr;
    assign w_hit    = !bus.req_we_i && (bus.req_addr_i >= BaseAddr) && (w_offset < RomBytes);

    // Counting the in-flight stage-1 slot keeps ready free of any resp_ready_i path.
    assign w_occupancy = {1'b0, w_count} + {{CntW{1'b0}}, r_s1_valid};
    assign w_ready     = (w_occupancy < DepthW);
    assign w_accept    = bus.req_valid_i && w_ready;

    assign rom_req_o  = w_accept && w_hit;
    assign rom_addr_o = (w_accept && w_hit) ? w_offset : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_err <= !w_hit;
            end
        end
    end

    assign w_push_data.rdata = r_s1_err ? '0 : rom_rdata_i;
    assign w_push_data.err   = r_s1_err;
    assign w_pop             = (w_count != '0) && bus.resp_ready_i;

    dm_rom_resp_fifo #(
        .Depth (FifoDepth)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (r_s1_valid),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.req_ready_o  = w_ready;
    assign bus.resp_valid_o = (w_count != '0);
    assign bus.resp_rdata_o = w_head.rdata;
    assign bus.resp_err_o   = w_head.err;

endmodule

// File: tb/tb_dm_rom_port.sv
// Directed bench for dm_rom_port with a one-cycle-latency ROM model.
module tb_dm_rom_port;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rom_req_o;
    logic [63:0] rom_addr_o;
    logic [63:0] rom_rdata_i = '0;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    localparam logic [63:0] W0   = 64'hCAFE0000_0000006F;
    localparam logic [63:0] W1   = 64'hCAFE0001_0000006F;
    localparam logic [63:0] W2   = 64'hCAFE0002_0000006F;
    localparam logic [63:0] W18  = 64'hCAFE0012_0000006F;
    localparam logic [63:0] JUNK = 64'hDEADBEEF_DEADBEEF;

    dm_rom_port_if bus();

    dm_rom_port #(
        .BaseAddr  (64'h800),
        .RomSize   (19),
        .FifoDepth (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .rom_req_o   (rom_req_o),
        .rom_addr_o  (rom_addr_o),
        .rom_rdata_i (rom_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // ROM word k reads as CAFE00kk_0000006F; idle cycles return junk.
    always @(posedge clk_i) begin
        rom_rdata_i <= rom_req_o ? {32'hCAFE0000 | {27'd0, rom_addr_o[7:3]}, 32'h0000006F} : JUNK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [63:0] addr);
        bus.req_valid_i = v;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic check_resp(input string tag, input logic [63:0] data, input logic err);
        check({tag, ".valid"}, 64'(bus.resp_valid_o), 64'd1);
        check({tag, ".rdata"}, bus.resp_rdata_o, data);
        check({tag, ".err"}, 64'(bus.resp_err_o), 64'(err));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"}, 64'(bus.req_ready_o), 64'd1);
        check({tag, ".rvalid"}, 64'(bus.resp_valid_o), 64'd0);
        check({tag, ".rdata"}, bus.resp_rdata_o, 64'd0);
        check({tag, ".err"}, 64'(bus.resp_err_o), 64'd0);
        check({tag, ".romreq"}, 64'(rom_req_o), 64'd0);
        check({tag, ".romaddr"}, rom_addr_o, 64'd0);
    endtask

    // Single error access with resp_ready_i held high.
    task automatic err_case(input string tag, input logic we, input logic [63:0] addr);
        cyc(); drive(1'b1, we, addr); #1;
        check({tag, ".romreq"}, 64'(rom_req_o), 64'd0);
        check({tag, ".romaddr"}, rom_addr_o, 64'd0);
        cyc(); drive(1'b0, 1'b0, '0);
        cyc(); check_resp(tag, 64'd0, 1'b1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, '0);
        bus.resp_ready_i = 1'b0;
        repeat (3) cyc();
        #1 check_idle_outputs("reset");
        cyc(); rst_ni = 1'b1; bus.resp_ready_i = 1'b1;

        // single read at the base address
        cyc(); drive(1'b1, 1'b0, 64'h800); #1;
        check("rd0.romreq", 64'(rom_req_o), 64'd1);
        check("rd0.romaddr", rom_addr_o, 64'd0);
        cyc(); drive(1'b0, 1'b0, '0);
        check("rd0.n1_valid", 64'(bus.resp_valid_o), 64'd0);
        cyc(); check_resp("rd0", W0, 1'b0);
        cyc(); check("rd0.drained", 64'(bus.resp_valid_o), 64'd0);

        // back-to-back reads at full throughput
        drive(1'b1, 1'b0, 64'h800); #1;
        check("b2b.rdy0", 64'(bus.req_ready_o), 64'd1);
        cyc(); drive(1'b1, 1'b0, 64'h808); #1;
        check("b2b.rdy1", 64'(bus.req_ready_o), 64'd1);
        check("b2b.addr1", rom_addr_o, 64'h8);
        cyc(); drive(1'b1, 1'b0, 64'h810); #1;
        check("b2b.rdy2", 64'(bus.req_ready_o), 64'd1);
        check("b2b.addr2", rom_addr_o, 64'h10);
        check_resp("b2b.r0", W0, 1'b0);
        cyc(); drive(1'b0, 1'b0, '0);
        check_resp("b2b.r1", W1, 1'b0);
        cyc(); check_resp("b2b.r2", W2, 1'b0);
        cyc(); check("b2b.drained", 64'(bus.resp_valid_o), 64'd0);

        // last valid word is a hit
        drive(1'b1, 1'b0, 64'h890); #1;
        check("last.romreq", 64'(rom_req_o), 64'd1);
        check("last.romaddr", rom_addr_o, 64'h90);
        cyc(); drive(1'b0, 1'b0, '0);
        cyc(); check_resp("last", W18, 1'b0);

        err_case("oob", 1'b0, 64'h898);
        err_case("wr", 1'b1, 64'h800);
        err_case("low", 1'b0, 64'h7F8);

        // hit/err/hit under backpressure
        cyc(); bus.resp_ready_i = 1'b0; drive(1'b1, 1'b0, 64'h808); #1;
        check("bp.rdy0", 64'(bus.req_ready_o), 64'd1);
        cyc(); drive(1'b1, 1'b0, 64'h900); #1;
        check("bp.rdy1", 64'(bus.req_ready_o), 64'd1);
        cyc(); drive(1'b1, 1'b0, 64'h810); #1;
        check("bp.rdy2", 64'(bus.req_ready_o), 64'd1);
        cyc(); drive(1'b1, 1'b0, 64'h818); #1;
        check("bp.full_rdy", 64'(bus.req_ready_o), 64'd0);
        check("bp.full_romreq", 64'(rom_req_o), 64'd0);
        cyc(); #1;
        check("bp.full2_rdy", 64'(bus.req_ready_o), 64'd0);
        check("bp.full2_romreq", 64'(rom_req_o), 64'd0);
        check_resp("bp.h0", W1, 1'b0);
        drive(1'b0, 1'b0, '0); bus.resp_ready_i = 1'b1;
        cyc(); #1;
        check("bp.rdy_back", 64'(bus.req_ready_o), 64'd1);
        check_resp("bp.h1", 64'd0, 1'b1);
        cyc(); check_resp("bp.h2", W2, 1'b0);
        cyc(); check("bp.drained", 64'(bus.resp_valid_o), 64'd0);

        // reset with one request in stage 1 and two stored entries
        bus.resp_ready_i = 1'b0; drive(1'b1, 1'b0, 64'h800);
        cyc(); drive(1'b1, 1'b0, 64'h808);
        cyc(); drive(1'b1, 1'b0, 64'h810);
        cyc(); drive(1'b0, 1'b0, '0);
        check("rst.pre_valid", 64'(bus.resp_valid_o), 64'd1);
        rst_ni = 1'b0; #1;
        check_idle_outputs("rst.mid");
        cyc(); rst_ni = 1'b1; bus.resp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); check("rst.no_stale", 64'(bus.resp_valid_o), 64'd0);
        end

        // misaligned read returns the containing word
        drive(1'b1, 1'b0, 64'h805); #1;
        check("mis.romreq", 64'(rom_req_o), 64'd1);
        check("mis.romaddr", rom_addr_o, 64'h5);
        cyc(); drive(1'b0, 1'b0, '0);
        cyc(); check_resp("mis", W0, 1'b0);
        cyc(); check("mis.drained", 64'(bus.resp_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_rom_port.md
# dm_rom_port

Request-side adapter placed directly upstream of the debug ROM in the debug module memory map. It accepts valid/ready read requests from the debug-memory slave port, decodes the ROM window, and issues single-cycle `req_o`/`addr_o` strobes to the ROM. It captures the ROM data one cycle later and returns ordered responses through a response FIFO that tolerates backpressure. Writes and out-of-window accesses get error responses and never reach the ROM.

## Interface
Parameters:
- `BaseAddr`, 64'h800: byte address of ROM word 0.
- `RomSize`, 19: ROM depth in 64-bit words.
- `FifoDepth`, 3: response FIFO entries. Minimum 2. Depth 3 or more gives one request per cycle under continuous `resp_ready_i`.

Ports (clock and reset first):
- `clk_i`, in, 1: clock. The block has one clock domain.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request accepted when both valid and ready are high.
- `req_we_i`, in, 1: write request.
- `req_addr_i`, in, 64: byte address.
- `resp_valid_o`, out, 1: response valid.
- `resp_ready_i`, in, 1: response consumed when both valid and ready are high.
- `resp_rdata_o`, out, 64: read data. Forced to 0 on error.
- `resp_err_o`, out, 1: error flag.
- `rom_req_o`, out, 1: ROM read strobe.
- `rom_addr_o`, out, 64: ROM byte offset. The ROM indexes with bits [7:3].
- `rom_rdata_i`, in, 64: ROM data. Valid exactly one cycle after `rom_req_o`.

## Operation
- Decode: `hit = !req_we_i && req_addr_i >= BaseAddr && (req_addr_i - BaseAddr) < RomSize*8`. The subtraction is 64-bit unsigned. `addr_i` bits [2:0] are ignored, so misaligned reads return the containing word.
- On acceptance:
  - `rom_req_o = hit`, driven combinationally in the same cycle.
  - `rom_addr_o = req_addr_i - BaseAddr` when hit, otherwise 0.
  - A stage-1 register loads `{valid=1, err=!hit}`.
- Next cycle: stage 1 writes into the FIFO `{rdata = err ? 0 : rom_rdata_i, err}`. Stage 1 clears unless a new request was accepted that cycle.
- FIFO pop: on `resp_valid_o && resp_ready_i`. A push and a pop in the same cycle are both performed, and the count is unchanged.
- Responses come out in strict acceptance order. Error and ROM responses share the same path, so they cannot reorder.
- `req_ready_o = (fifo_count + s1_valid) < FifoDepth`. It is computed from registers only and has no combinational path from `resp_ready_i`.
- `resp_valid_o = fifo_count != 0`. `resp_rdata_o` and `resp_err_o` show the head entry and are 0 when the FIFO is empty.
- Errors: any write, address below `BaseAddr`, or offset of `RomSize*8` or more.
- Overflow cannot occur by construction. Verification asserts that no push happens when the FIFO is full.

## Timing
- Reset values: `req_ready_o=1` (after reset only, since count=0), `resp_valid_o=0`, `resp_rdata_o=0`, `resp_err_o=0`, `rom_req_o=0`, `rom_addr_o=0`.
- Latency: accept in cycle N, ROM data in N+1, `resp_valid_o` earliest in N+2. Errors have the same latency.
- Throughput: one request per cycle when `FifoDepth` is 3 or more and `resp_ready_i` is held high.
- Full: `req_ready_o` drops in the cycle the in-flight request plus stored entries reach `FifoDepth`. It rises again the cycle after a pop frees space.
- Reset asserted mid-operation: the stage-1 register and the FIFO clear immediately. In-flight ROM data is discarded and no response is ever produced for it.
- `rom_req_o` is never high while `req_ready_o` is low.

## Structure
- `dm_rom_pkg`:
  - `rom_resp_t` = `{logic [63:0] rdata; logic err;}`
  - `DbgRomBase = 64'h800`
  - `DbgRomWords = 19`
- One sub-module, `dm_rom_resp_fifo`: parameterized by depth, with push/pop/count and a head output. It is a circular buffer with wrap-around pointers and a `$clog2(FifoDepth+1)`-bit count.
- The top level holds decode, the stage-1 register and the ready logic.

## Test plan
- Reset, then one read at 0x800: `rom_req_o=1` and `rom_addr_o=0` in cycle N; model drives `rom_rdata_i=64'h...006f` in N+1. Expect `resp_valid_o` in N+2 with that data and `err=0`.
- Back-to-back reads 0x800, 0x808, 0x810 with `resp_ready_i=1`: `req_ready_o` stays 1; three responses return in order in consecutive cycles.
- Error cases:
  - Read 0x898 (offset 152 = 19*8): `rom_req_o=0`, response `err=1`, `rdata=0`.
  - Write 0x800: same error response.
  - Read 0x7F8: same error response.
- Interleaved hit/error/hit with `resp_ready_i=0`: `req_ready_o` falls after three accepts. Release ready: responses come out in order hit, err, hit; `req_ready_o` returns one cycle after the first pop.
- Assert `rst_ni=0` with one request in stage 1 and two entries in the FIFO: outputs go to reset values immediately; after release, no stale response appears.
- Read 0x805 (misaligned): `rom_addr_o=5`; returns word 0 data, `err=0`.
